onehot_seq_fsm: RTL and testbench

- Parametrised one-hot sequencer; successor to the 4-state run/mode stepper.
- Steps through NUM_STATES states, driving a one-hot vector.
- Adds per-state skip mask (generalises the old mode branch), up/down direction, programmable dwell time, one-shot mode, wrap/done status and asynchronous reset.
- Drives downstream phase enables in the same clock domain.

---
 rtl/onehot_seq_fsm.sv | 111 +++++++++++
 tb/tb_onehot_seq_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_fsm.sv
// onehot_seq_fsm: parametrised one-hot sequencer with per-state skip mask,
// up/down direction, programmable dwell, one-shot mode and wrap/done status.
// Drives downstream phase enables in the same clock domain.

module onehot_seq_fsm #(
    parameter int NUM_STATES = 4,
    parameter int DWELL_W    = 4,
    parameter int IDX_W      = $clog2(NUM_STATES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic                  dir_i,
    input  logic                  oneshot_i,
    input  logic [NUM_STATES-1:0] skip_mask_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [NUM_STATES-1:0] vector_o,
    output logic [IDX_W-1:0]      state_idx_o,
    output logic                  wrap_o,
    output logic                  done_o
);

    // Registered state and its next-state values
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;

    // Search helpers for the advance target
    logic [NUM_STATES-1:0] effMask;
    logic [IDX_W-1:0]      candIdx;
    logic [IDX_W-1:0]      targetIdx;
    logic                  targetFound;
    logic                  idxLegal;

    // State 0 can never be skipped, so its mask bit is forced low
    assign effMask  = {skip_mask_i[NUM_STATES-1:1], 1'b0};

    // Indices at or above NUM_STATES only exist when NUM_STATES is not a power of two
    assign idxLegal = (int'(idx_q) < NUM_STATES);

    // State register: index, dwell counter and the two registered status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    // Next-state logic: dwell counting, nearest unmasked successor search, wrap and one-shot
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        done_d      = done_q;
        candIdx     = '0;
        targetIdx   = idx_q;
        targetFound = 1'b0;

        // Walk outward from the current index and keep the first unmasked candidate
        for (int k = 1; k < NUM_STATES; k++) begin
            if (dir_i) begin
                candIdx = IDX_W'((int'(idx_q) + NUM_STATES - k) % NUM_STATES);
            end else begin
                candIdx = IDX_W'((int'(idx_q) + k) % NUM_STATES);
            end
            if (!targetFound && !effMask[candIdx]) begin
                targetFound = 1'b1;
                targetIdx   = candIdx;
            end
        end

        if (!idxLegal) begin
            idx_d  = '0;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (!run_i) begin
            done_d = 1'b0;
        end else if (done_q) begin
            done_d = 1'b1;
        end else if (cnt_q >= dwell_i) begin
            cnt_d = '0;
            if (targetFound) begin
                idx_d  = targetIdx;
                wrap_d = dir_i ? (targetIdx > idx_q) : (targetIdx < idx_q);
                done_d = oneshot_i && wrap_d;
            end
        end else begin
            cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
        end
    end

    // Output decode: one-hot vector from the index, status flags straight from registers
    always_comb begin
        vector_o = '0;
        if (idxLegal) begin
            vector_o[idx_q] = 1'b1;
        end
        state_idx_o = idx_q;
        wrap_o      = wrap_q;
        done_o      = done_q;
    end

endmodule

// File: tb/tb_onehot_seq_fsm.sv
// tb_onehot_seq_fsm: directed-vector bench for onehot_seq_fsm (NUM_STATES=4, DWELL_W=4).

module tb_onehot_seq_fsm;

    logic       clk;
    logic       rst;
    logic       run;
    logic       dir;
    logic       oneshot;
    logic [3:0] skipMask;
    logic [3:0] dwell;
    logic [3:0] vector;
    logic [1:0] stateIdx;
    logic       wrap;
    logic       done;

    int numChecks;
    int numFails;

    onehot_seq_fsm #(
        .NUM_STATES(4),
        .DWELL_W   (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .run_i      (run),
        .dir_i      (dir),
        .oneshot_i  (oneshot),
        .skip_mask_i(skipMask),
        .dwell_i    (dwell),
        .vector_o   (vector),
        .state_idx_o(stateIdx),
        .wrap_o     (wrap),
        .done_o     (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Check the full visible state of the sequencer
    task automatic expectState(input string tag, input logic [3:0] expVec, input logic [1:0] expIdx,
                               input logic expWrap, input logic expDone);
        checkOutput({tag, ".vector"}, 32'(vector), 32'(expVec));
        checkOutput({tag, ".idx"},    32'(stateIdx), 32'(expIdx));
        checkOutput({tag, ".wrap"},   32'(wrap), 32'(expWrap));
        checkOutput({tag, ".done"},   32'(done), 32'(expDone));
    endtask

    // Drive all functional inputs at once
    task automatic applyStimulus(input logic r, input logic d, input logic os,
                                 input logic [3:0] m, input logic [3:0] dw);
        run      = r;
        dir      = d;
        oneshot  = os;
        skipMask = m;
        dwell    = dw;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse that leaves the DUT at idx 0, cnt 0
    task automatic resetDut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0);

        // Reset state, observed before any clock edge
        #2;
        expectState("reset", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Plain ascending sequence, one state per cycle
        $display("[TB] ascending, no mask");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0);
        expectState("asc0", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("asc1", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expectState("asc2", 4'b0100, 2'd2, 1'b0, 1'b0);
        tick(); expectState("asc3", 4'b1000, 2'd3, 1'b0, 1'b0);
        tick(); expectState("asc4", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); expectState("asc5", 4'b0010, 2'd1, 1'b0, 1'b0);

        // Skip state 2 (legacy mode=0), with and without bit 0 set
        for (int pass = 0; pass < 2; pass++) begin
            $display("[TB] skip mask pass %0d", pass);
            resetDut();
            applyStimulus(1'b1, 1'b0, 1'b0, (pass == 0) ? 4'b0100 : 4'b0101, 4'd0);
            expectState("skip0", 4'b0001, 2'd0, 1'b0, 1'b0);
            tick(); expectState("skip1", 4'b0010, 2'd1, 1'b0, 1'b0);
            tick(); expectState("skip2", 4'b1000, 2'd3, 1'b0, 1'b0);
            tick(); expectState("skip3", 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        // Everything except state 0 masked: no movement, no wrap
        $display("[TB] all-masked");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1110, 4'd0);
        tick(); expectState("allm1", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("allm2", 4'b0001, 2'd0, 1'b0, 1'b0);

        // Dwell of 2 with a run-low freeze inside state 1
        $display("[TB] dwell and freeze");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'd2);
        expectState("dw0", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("dw1", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("dw2", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("dw3", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); expectState("frz", 4'b0010, 2'd1, 1'b0, 1'b0);
        end
        run = 1'b1;
        expectState("dwr0", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expectState("dwr1", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expectState("dwr2", 4'b0100, 2'd2, 1'b0, 1'b0);

        // Descending order from reset
        $display("[TB] descending");
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 4'd0);
        tick(); expectState("dsc1", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); expectState("dsc2", 4'b0100, 2'd2, 1'b0, 1'b0);
        tick(); expectState("dsc3", 4'b0010, 2'd1, 1'b0, 1'b0);
        tick(); expectState("dsc4", 4'b0001, 2'd0, 1'b0, 1'b0);

        // One-shot: halt after one pass, re-arm with a run-low cycle
        $display("[TB] one-shot");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 4'd0);
        tick(); tick(); tick();
        expectState("os3", 4'b1000, 2'd3, 1'b0, 1'b0);
        tick(); expectState("os4", 4'b0001, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(); expectState("osHold", 4'b0001, 2'd0, 1'b0, 1'b1);
        end
        oneshot = 1'b0;
        tick(); expectState("osKeep", 4'b0001, 2'd0, 1'b0, 1'b1);
        run = 1'b0;
        tick(); expectState("osClr", 4'b0001, 2'd0, 1'b0, 1'b0);
        run = 1'b1;
        tick(); expectState("osRes", 4'b0010, 2'd1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while in state 2 with cnt 1
        $display("[TB] async reset");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'd2);
        tick(); tick(); tick();
        tick(); tick(); tick();
        tick();
        expectState("arPre", 4'b0100, 2'd2, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expectState("arAsync", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        expectState("ar0", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("ar1", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("ar2", 4'b0001, 2'd0, 1'b0, 1'b0);
        tick(); expectState("ar3", 4'b0010, 2'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
